// File: rtl/ola_pkg.sv
// ola_pkg
// Shared definitions for the overlap-add octave-shift block: default
// parameter values, the controller state encoding and the saturating adder
// used when a new half-frame is summed with the stored tail.
// No ports (package).

package ola_pkg;

    localparam int OLA_W_DEF       = 16;
    localparam int OLA_LOG_N_DEF   = 11;
    localparam int OLA_MAX_OCT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } ola_state_t;

    // Adds two w-bit signed values (sign-extended into 32 bits) with one
    // guard bit of headroom and clamps to the w-bit signed range instead of
    // wrapping. Valid for w up to 31.
    function automatic logic signed [31:0] ola_sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -hi - 33'sd1;
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return 32'(s);
    endfunction

endpackage

// File: rtl/ola_dpram.sv
// ola_dpram
// Simple dual-port RAM: one write port, one registered read port, same clock.
// Contents are never reset; the read register updates every cycle so holding
// i_raddr holds o_rdata.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (data appears one cycle later)
//   o_rdata  registered read data

module ola_dpram #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ola_octave_shift.sv
// ola_octave_shift
// Overlap-add of ISTFT frames (hop = half a frame) followed by power-of-two
// decimation of the finished half-frame. The first half of each incoming
// frame is added to the stored second half of the previous frame; the second
// half becomes the new tail. The summed half-frame is then streamed out,
// keeping every 2^oct-th sample.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset; pre-reads tail[0], enters LOAD next cycle
//   LOAD  | accepts N input beats; first half summed, second half stored
//   EMIT  | streams H>>oct decimated sums, then back to LOAD
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   oct_sel                octave shift, latched on the first beat of a frame
//   in_valid/ready/data    ISTFT sample stream (signed, windowed)
//   out_valid/ready/data   decimated overlap-added stream
//   frame_done             pulse on the last output beat of a frame
//   primed                 a full frame has been loaded since reset

module ola_octave_shift
    import ola_pkg::*;
#(
    parameter int W       = OLA_W_DEF,
    parameter int LOG_N   = OLA_LOG_N_DEF,
    parameter int MAX_OCT = OLA_MAX_OCT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          oct_sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                frame_done,
    output logic                primed
);

    localparam int H  = 1 << (LOG_N - 1);
    localparam int AW = LOG_N - 1;

    ola_state_t       r_state;
    logic [LOG_N-1:0] r_cnt;
    logic [AW-1:0]    r_j;
    logic [1:0]       r_oct;
    logic             r_primed;
    logic             r_out_valid;

    logic                w_in_beat;
    logic                w_out_beat;
    logic                w_last_out;
    logic [1:0]          w_oct_clamped;
    logic [LOG_N-1:0]    w_n_out;
    logic [AW-1:0]       w_j_next;
    logic [AW-1:0]       w_emit_addr;
    logic [AW-1:0]       w_load_addr;
    logic [AW-1:0]       w_rd_addr;
    logic [W-1:0]        w_sum_rdata;
    logic [W-1:0]        w_tail_rdata;
    logic signed [W-1:0] w_tail;
    logic signed [W-1:0] w_sum;

    assign w_in_beat  = (r_state == ST_LOAD) && in_valid;
    assign w_out_beat = r_out_valid && out_ready;

    assign w_oct_clamped = (int'(oct_sel) > MAX_OCT) ? 2'(MAX_OCT) : oct_sel;

    assign w_n_out    = LOG_N'(H) >> r_oct;
    assign w_last_out = ({1'b0, r_j} == (w_n_out - LOG_N'(1)));

    // The RAM read is registered, so the address always names the word that
    // must be on the read port next cycle. After the last output beat the
    // shifted index equals H and truncates to 0, which is exactly the tail
    // word the following LOAD needs first.
    assign w_j_next    = w_out_beat ? (r_j + AW'(1)) : r_j;
    assign w_emit_addr = w_j_next << r_oct;
    assign w_load_addr = w_in_beat ? (r_cnt[AW-1:0] + AW'(1)) : r_cnt[AW-1:0];

    always_comb begin
        w_rd_addr = '0;
        case (r_state)
            ST_LOAD: w_rd_addr = w_load_addr;
            ST_EMIT: w_rd_addr = w_emit_addr;
            default: w_rd_addr = '0;
        endcase
    end

    // Tail contents are stale after reset until a full frame has refilled them.
    assign w_tail = r_primed ? w_tail_rdata : '0;
    assign w_sum  = W'(ola_sat_add(32'(in_data), 32'(w_tail), W));

    ola_dpram #(
        .W     (W),
        .DEPTH (H),
        .AW    (AW)
    ) u_sum_buf (
        .clk     (clk),
        .i_we    (w_in_beat && !r_cnt[LOG_N-1]),
        .i_waddr (r_cnt[AW-1:0]),
        .i_wdata (w_sum),
        .i_raddr (w_rd_addr),
        .o_rdata (w_sum_rdata)
    );

    ola_dpram #(
        .W     (W),
        .DEPTH (H),
        .AW    (AW)
    ) u_tail_buf (
        .clk     (clk),
        .i_we    (w_in_beat && r_cnt[LOG_N-1]),
        .i_waddr (r_cnt[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_tail_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_j         <= '0;
            r_oct       <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_in_beat) begin
                        if (r_cnt == '0) begin
                            r_oct <= w_oct_clamped;
                        end
                        r_cnt <= r_cnt + LOG_N'(1);
                        if (&r_cnt) begin
                            r_primed <= 1'b1;
                            r_j      <= '0;
                            r_state  <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    // First EMIT cycle only issues the read of sum[0].
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (w_out_beat) begin
                        if (w_last_out) begin
                            r_out_valid <= 1'b0;
                            r_j         <= '0;
                            r_state     <= ST_LOAD;
                        end else begin
                            r_j <= r_j + AW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == ST_LOAD);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_valid ? w_sum_rdata : '0;
    assign frame_done = w_out_beat && w_last_out;
    assign primed     = r_primed;

endmodule

// File: tb/tb_ola_octave_shift.sv
module tb_ola_octave_shift;

    localparam int W       = 16;
    localparam int LOG_N   = 4;
    localparam int MAX_OCT = 2;
    localparam int N       = 16;
    localparam int H       = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  oct_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        frame_done;
    logic        primed;

    always #5 clk = ~clk;

    ola_octave_shift #(
        .W       (W),
        .LOG_N   (LOG_N),
        .MAX_OCT (MAX_OCT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .oct_sel    (oct_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_done (frame_done),
        .primed     (primed)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [15:0] d;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] got[$];
    logic [15:0] m_tail[H];
    bit          m_primed;
    int          n_fd = 0;
    bit          rdy_rand = 0;
    bit          vld_rand = 0;
    logic [15:0] frm[N];

    function automatic logic [15:0] m_sat(input int s);
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    // Overlap-add the first half against the previous tail, keep every
    // 2^oct-th sum, then remember the second half as the next tail.
    task automatic model_frame(input logic [15:0] x[N], input int oct);
        int o;
        int n;
        int t;
        logic [15:0] s[H];
        o = (oct > MAX_OCT) ? MAX_OCT : oct;
        for (int k = 0; k < H; k++) begin
            t = m_primed ? int'($signed(m_tail[k])) : 0;
            s[k] = m_sat(int'($signed(x[k])) + t);
        end
        n = H / (1 << o);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back('{d: s[j * (1 << o)], last: (j == n - 1)});
        end
        for (int k = 0; k < H; k++) m_tail[k] = x[k + H];
        m_primed = 1;
    endtask

    // ---------------- output compare process ----------------
    logic        prev_v = 0;
    logic        prev_r = 0;
    logic [15:0] prev_d = 0;
    logic        fd_prev = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v  = 0;
            prev_r  = 0;
            fd_prev = 0;
        end else begin
            if (fd_prev) chk("no_idle_after_frame", in_ready, 1);
            if (!out_valid) begin
                chk("data_zero_when_idle", out_data, 0);
                chk("frame_done_no_valid", frame_done, 0);
            end else begin
                if (prev_v && !prev_r) chk("hold_under_stall", out_data, prev_d);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", out_data, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("frame_done", frame_done, e.last);
                        got.push_back(out_data);
                    end
                end else begin
                    chk("frame_done_stalled", frame_done, 0);
                end
            end
            if (frame_done) n_fd++;
            prev_v  = out_valid;
            prev_r  = out_ready;
            prev_d  = out_data;
            fd_prev = frame_done;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic load_frame(input logic [15:0] x[N], input logic [1:0] oct_first,
                              input logic [1:0] oct_later, input int n_beats);
        int i = 0;
        int guard = 0;
        while (i < n_beats && guard < 400) begin
            in_valid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = x[i];
            oct_sel  = (i == 0) ? oct_first : oct_later;
            @(negedge clk);
            if (in_valid && in_ready) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("load_beats", i, n_beats);
        if (n_beats == N) begin
            @(negedge clk);
            chk("lat_cycle1_valid", out_valid, 0);
            chk("lat_cycle1_ready", in_ready, 0);
            @(negedge clk);
            chk("lat_cycle2_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input logic [15:0] x[N], input logic [1:0] oct_first,
                             input logic [1:0] oct_later);
        model_frame(x, int'(oct_first));
        load_frame(x, oct_first, oct_later, N);
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(posedge clk);
            #2;
            g++;
        end
        chk("drain_complete", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int k = 0; k < N; k++) frm[k] = v;
    endtask

    initial begin
        int fd0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        oct_sel  = '0;
        m_primed = 0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_primed", primed, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // first frame: zero tail
        fill(16'h0100);
        got.delete();
        fd0 = n_fd;
        run_frame(frm, 2'd0, 2'd0);
        chk("t1_primed", primed, 1);
        drain();
        chk("t1_count", got.size(), 8);
        chk("t1_first", got[0], 16'h0100);
        chk("t1_last", got[7], 16'h0100);
        chk("t1_frame_done_once", n_fd - fd0, 1);

        // second frame, oct 2: indices 0 and 4 of the doubled sum
        got.delete();
        run_frame(frm, 2'd2, 2'd2);
        drain();
        chk("t2_count", got.size(), 2);
        chk("t2_out0", got[0], 16'h0200);
        chk("t2_out1", got[1], 16'h0200);

        // saturation both ways
        fill(16'h7000);
        got.delete();
        run_frame(frm, 2'd0, 2'd0);
        run_frame(frm, 2'd0, 2'd0);
        drain();
        chk("t3p_count", got.size(), 16);
        chk("t3p_first", got[0], 16'h7100);
        chk("t3p_sat", got[15], 16'h7FFF);

        fill(16'h9000);
        got.delete();
        run_frame(frm, 2'd0, 2'd0);
        run_frame(frm, 2'd0, 2'd0);
        drain();
        chk("t3n_first", got[0], 16'h0000);
        chk("t3n_sat", got[15], 16'h8000);

        // ramp with random stalls on both sides
        for (int k = 0; k < N; k++) frm[k] = 16'(k);
        rdy_rand = 1;
        vld_rand = 1;
        got.delete();
        run_frame(frm, 2'd1, 2'd1);
        run_frame(frm, 2'd1, 2'd1);
        drain();
        rdy_rand = 0;
        vld_rand = 0;
        chk("t4_count", got.size(), 8);
        chk("t4_out0", got[0], 16'h9000);
        chk("t4_out3", got[3], 16'h9006);
        chk("t4_out4", got[4], 16'h0008);
        chk("t4_out7", got[7], 16'h0014);

        // reset at LOAD beat 10 aborts the frame and discards the tail
        fill(16'h0100);
        load_frame(frm, 2'd0, 2'd0, 10);
        rst_n = 1'b0;
        m_primed = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_rst_primed", primed, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_primed_before_load", primed, 0);
        @(posedge clk);
        #1;
        got.delete();
        run_frame(frm, 2'd0, 2'd0);
        chk("t5_primed_after_load", primed, 1);
        drain();
        chk("t5_count", got.size(), 8);
        chk("t5_out0", got[0], 16'h0100);

        // clamp and mid-frame oct_sel changes
        got.delete();
        run_frame(frm, 2'd3, 2'd3);
        drain();
        chk("t6_clamp_count", got.size(), 2);
        chk("t6_clamp_out0", got[0], 16'h0200);

        got.delete();
        run_frame(frm, 2'd0, 2'd3);
        drain();
        chk("t6_toggle_up_count", got.size(), 8);

        got.delete();
        run_frame(frm, 2'd2, 2'd0);
        drain();
        chk("t6_toggle_down_count", got.size(), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
